i2s_rx: RTL and testbench
=========================

I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 Parameter DATA_W, default 16, bits per channel word.
REQ-002 Parameter TIMEOUT, default 255, clk cycles without a BCK rising edge before the link is declared lost.
REQ-003 Parameter LJ, default 1: 1 = left-justified (MSB on the edge where WS changes), 0 = Philips I2S (MSB one BCK after the WS change).
REQ-004 Port clk, input, 1, system clock; all logic on its rising edge; at least 8x the BCK frequency.
REQ-005 Port reset_n, input, 1, asynchronous active-low reset.
REQ-006 Port i2s_bck, input, 1, serial bit clock, asynchronous to clk.
REQ-007 Port i2s_ws, input, 1, word select: 0 = left, 1 = right; asynchronous.
REQ-008 Port i2s_din, input, 1, serial data, MSB first; asynchronous.
REQ-009 Port audio_l, output, DATA_W, last complete left sample.
REQ-010 Port audio_r, output, DATA_W, last complete right sample.
REQ-011 Port sample_valid, output, 1, one-clk pulse when audio_l/audio_r update as a pair.
REQ-012 Port frame_err, output, 1, one-clk pulse on a short word.
REQ-013 Port locked, output, 1, high while a valid stream is being received.

Function
REQ-014 i2s_bck, i2s_ws and i2s_din SHALL each pass through a 2-FF synchronizer; a BCK rising edge is detected from the synchronized BCK and its delayed copy.
REQ-015 WS and DIN SHALL be sampled only in the clk cycle in which a BCK rising edge is detected.
REQ-016 States: IDLE, SHIFT_L, SHIFT_R. Reset enters IDLE.
REQ-017 IDLE -> SHIFT_L on a sampled WS 1->0 transition; IDLE -> SHIFT_R on a sampled WS 0->1 transition. No word is committed from IDLE.
REQ-018 Within a SHIFT state, each BCK edge shifts DIN into the word register. The bit counter saturates at DATA_W; further bits are ignored.
REQ-019 LJ=1: the bit on the WS-change edge is the new word's MSB. LJ=0: the bit on the WS-change edge belongs to the previous word, and the next edge carries the MSB.
REQ-020 At a WS change with count == DATA_W, the word is committed to the channel of the previous WS. A left commit sets left_held. A right commit with left_held set loads audio_l/audio_r, pulses sample_valid, sets locked and clears left_held.
REQ-021 sample_valid SHALL assert exactly 1 clk after the cycle in which the committing BCK edge is detected.
REQ-022 At a WS change with count < DATA_W: pulse frame_err, discard the word, clear left_held, and continue in the state selected by the new WS. Outputs hold.
REQ-023 A right word committed without left_held SHALL be dropped silently.
REQ-024 If TIMEOUT clk cycles pass with no BCK edge: go to IDLE, clear locked and left_held. audio_l/audio_r retain their values.
REQ-025 If a BCK edge and timeout expiry occur in the same cycle, the edge wins and the timeout counter clears.

Reset
REQ-026 On reset_n low: audio_l = 0, audio_r = 0, sample_valid = 0, frame_err = 0, locked = 0, state IDLE, counters 0, synchronizers 0.
REQ-027 Reset asserted mid-word SHALL abort the word with no output pulse; the first pair after release requires a fresh WS edge.

Configuration
REQ-028 With macro I2S_RX_OFFSET_BIN_EN defined, committed words SHALL have their MSB inverted, converting offset-binary to two's complement. Without it, words pass unmodified.

Structure
REQ-029 Shared package audio_pkg SHALL hold the state encoding (IDLE/SHIFT_L/SHIFT_R) and the default DATA_W/TIMEOUT constants.
REQ-030 A single sub-module i2s_sync SHALL implement the 2-FF synchronizer plus BCK rising-edge detect; all else lives in i2s_rx.

Verification
REQ-031 LJ=1, clk 31.5 MHz, BCK 768 kHz, frames L=16'h1234 R=16'hABCD -> sample_valid pulses once per frame; audio_l=16'h1234, audio_r=16'hABCD; locked=1 after the first pair.
REQ-032 LJ=0, same stream with the 1-BCK MSB delay -> identical outputs to REQ-031.
REQ-033 Right word truncated to 10 bits -> one frame_err pulse, no sample_valid, outputs unchanged; next full frame recovers.
REQ-034 BCK stopped for 300 clk -> locked=0 at cycle 255 after the last edge, outputs hold; restarted stream -> first pair only after the WS 1->0 and a complete L,R.
REQ-035 I2S_RX_OFFSET_BIN_EN defined, input L=R=16'h8000 -> audio_l=audio_r=16'h0000.
REQ-036 reset_n pulsed low mid-left-word -> all outputs 0 immediately; no pulse until the next complete L,R pair.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg: receiver state encoding and default word/timeout sizes
// shared by the I2S receiver files.
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT_L = 2'd1,
        SHIFT_R = 2'd2
    } rx_state_t;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/i2s_sync.sv
// i2s_sync: 2-FF synchronizers for BCK/WS/DIN plus BCK rising-edge detect.
// Ports: clk, reset_n in; i2s_bck/ws/din in; bck_rise, ws_s, din_s out.
module i2s_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic i2s_bck,
    input  logic i2s_ws,
    input  logic i2s_din,
    output logic bck_rise,
    output logic ws_s,
    output logic din_s
);

    logic [1:0] bck_q;
    logic [1:0] ws_q;
    logic [1:0] din_q;
    logic       bck_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bck_q <= '0;
            ws_q  <= '0;
            din_q <= '0;
            bck_d <= 1'b0;
        end else begin
            bck_q <= {bck_q[0], i2s_bck};
            ws_q  <= {ws_q[0], i2s_ws};
            din_q <= {din_q[0], i2s_din};
            bck_d <= bck_q[1];
        end
    end

    assign bck_rise = bck_q[1] & ~bck_d;
    assign ws_s     = ws_q[1];
    assign din_s    = din_q[1];

endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: I2S / left-justified serial audio receiver producing L/R pairs.
// Ports: clk, reset_n, i2s_bck/ws/din in; audio_l/r, sample_valid,
// frame_err, locked out. Define I2S_RX_OFFSET_BIN_EN to invert word MSBs.
module i2s_rx
    import audio_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int LJ      = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i2s_bck,
    input  logic              i2s_ws,
    input  logic              i2s_din,
    output logic [DATA_W-1:0] audio_l,
    output logic [DATA_W-1:0] audio_r,
    output logic              sample_valid,
    output logic              frame_err,
    output logic              locked
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] FULL  = CW'(DATA_W);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    logic              bck_rise;
    logic              ws_s;
    logic              din_s;
    rx_state_t         state;
    rx_state_t         state_nx;
    logic              ws_prev;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     fin_cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] word_sh;
    logic [DATA_W-1:0] fin_word;
    logic [DATA_W-1:0] word_out;
    logic [DATA_W-1:0] lhold;
    logic              left_held;
    logic [TW-1:0]     tcnt;
    logic              ws_chg;
    logic              tmo;
    logic              room;
    logic              commit_l;
    logic              commit_r;
    logic              short_w;

    i2s_sync u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .i2s_bck  (i2s_bck),
        .i2s_ws   (i2s_ws),
        .i2s_din  (i2s_din),
        .bck_rise (bck_rise),
        .ws_s     (ws_s),
        .din_s    (din_s)
    );

    assign ws_chg  = bck_rise && (ws_s != ws_prev);
    // a BCK edge in the expiry cycle keeps the link alive
    assign tmo     = !bck_rise && (tcnt == TLAST);
    assign room    = (cnt != FULL);
    assign word_sh = {shreg[DATA_W-2:0], din_s};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (tmo)
            state_nx = IDLE;
        else if (ws_chg)
            state_nx = ws_s ? SHIFT_R : SHIFT_L;
    end

    always_comb begin
        fin_cnt  = cnt;
        fin_word = shreg;
        commit_l = 1'b0;
        commit_r = 1'b0;
        short_w  = 1'b0;
        // Philips mode: the WS-change bit still closes the old word
        if (LJ == 0 && room) begin
            fin_cnt  = cnt + 1'b1;
            fin_word = word_sh;
        end
        if (ws_chg) begin
            unique case (state)
                SHIFT_L: begin
                    commit_l = (fin_cnt == FULL);
                    short_w  = (fin_cnt != FULL);
                end
                SHIFT_R: begin
                    commit_r = (fin_cnt == FULL);
                    short_w  = (fin_cnt != FULL);
                end
                default: ;
            endcase
        end
    end

`ifdef I2S_RX_OFFSET_BIN_EN
    assign word_out = {~fin_word[DATA_W-1], fin_word[DATA_W-2:0]};
`else
    assign word_out = fin_word;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ws_prev      <= 1'b0;
            cnt          <= '0;
            shreg        <= '0;
            lhold        <= '0;
            left_held    <= 1'b0;
            tcnt         <= '0;
            audio_l      <= '0;
            audio_r      <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            locked       <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            if (bck_rise) begin
                tcnt    <= '0;
                ws_prev <= ws_s;
            end else if (!tmo) begin
                tcnt <= tcnt + 1'b1;
            end
            if (tmo) begin
                cnt       <= '0;
                left_held <= 1'b0;
                locked    <= 1'b0;
            end else if (ws_chg) begin
                if (LJ != 0) begin
                    shreg <= {{(DATA_W-1){1'b0}}, din_s};
                    cnt   <= CW'(1);
                end else begin
                    shreg <= '0;
                    cnt   <= '0;
                end
            end else if (bck_rise && state != IDLE && room) begin
                shreg <= word_sh;
                cnt   <= cnt + 1'b1;
            end
            if (commit_l) begin
                lhold     <= word_out;
                left_held <= 1'b1;
            end
            if (commit_r && left_held) begin
                audio_l      <= lhold;
                audio_r      <= word_out;
                sample_valid <= 1'b1;
                locked       <= 1'b1;
                left_held    <= 1'b0;
            end
            if (short_w) begin
                frame_err <= 1'b1;
                left_held <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: drives one word stream into a left-justified and a Philips
// receiver and compares both against a word-level reference model.
module tb_i2s_rx;

    localparam int PER = 10;
    localparam int H   = 8;

    typedef struct {
        bit          ch;
        int          len;
        logic [15:0] v;
    } word_t;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          rlen;
        logic [15:0] el;
        logic [15:0] er;
        int          esv;
        int          efe;
        bit          elock;
    } vec_t;

    logic clk, reset_n, bck, ws, din_lj, din_is;
    logic [15:0] al1, ar1, al2, ar2;
    logic sv1, fe1, lk1, sv2, fe2, lk2;

    int tot, bad;
    int n_sv1, n_sv2, n_fe1, n_fe2;
    time last_rise_t;
    bit last_d;
    word_t wq[$];
    vec_t tab[5];

    logic [15:0] m_l, m_r, m_hold;
    bit m_hf, m_lock, m_prev;
    int e_sv, e_fe;

    i2s_rx #(.DATA_W(16), .TIMEOUT(255), .LJ(1)) u_lj (
        .clk(clk), .reset_n(reset_n), .i2s_bck(bck), .i2s_ws(ws),
        .i2s_din(din_lj), .audio_l(al1), .audio_r(ar1),
        .sample_valid(sv1), .frame_err(fe1), .locked(lk1)
    );

    i2s_rx #(.DATA_W(16), .TIMEOUT(255), .LJ(0)) u_is (
        .clk(clk), .reset_n(reset_n), .i2s_bck(bck), .i2s_ws(ws),
        .i2s_din(din_is), .audio_l(al2), .audio_r(ar2),
        .sample_valid(sv2), .frame_err(fe2), .locked(lk2)
    );

    initial clk = 1'b0;
    always #(PER/2) clk = ~clk;

    function automatic logic [15:0] cv(input logic [15:0] v);
`ifdef I2S_RX_OFFSET_BIN_EN
        return {~v[15], v[14:0]};
`else
        return v;
`endif
    endfunction

    function automatic bit bitof(input word_t w, input int j);
        return (j < 16) ? w.v[15-j] : 1'b1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // sample_valid must appear 3 clk after the BCK rise (2 sync + 1 reg)
    always @(negedge clk) begin
        if (reset_n) begin
            if (sv1) begin
                n_sv1++;
                chk("sv_lat_lj", 32'($time - last_rise_t), 32'(3*PER));
            end
            if (sv2) begin
                n_sv2++;
                chk("sv_lat_is", 32'($time - last_rise_t), 32'(3*PER));
            end
            if (fe1) n_fe1++;
            if (fe2) n_fe2++;
        end
    end

    // one BCK period; Philips DIN carries the previous slot's bit
    task automatic drive_slot(input bit w, input bit d);
        bck = 1'b0;
        ws = w;
        din_is = last_d;
        din_lj = d;
        last_d = d;
        repeat (H) @(negedge clk);
        bck = 1'b1;
        last_rise_t = $time;
        repeat (H) @(negedge clk);
    endtask

    task automatic run_words();
        foreach (wq[i])
            for (int j = 0; j < wq[i].len; j++)
                drive_slot(wq[i].ch, bitof(wq[i], j));
    endtask

    task automatic push(input bit ch, input int len, input logic [15:0] v);
        word_t w;
        w.ch = ch;
        w.len = len;
        w.v = v;
        wq.push_back(w);
    endtask

    // Word-level model: a word counts only if the stream was live when it
    // began (WS changed into it); it is judged when the next word starts.
    task automatic model_run();
        bit tr;
        e_sv = 0;
        e_fe = 0;
        tr = (wq[0].ch != m_prev);
        for (int i = 0; i < wq.size() - 1; i++) begin
            if (tr) begin
                if (wq[i].len >= 16) begin
                    if (!wq[i].ch) begin
                        m_hold = cv(wq[i].v);
                        m_hf = 1'b1;
                    end else if (m_hf) begin
                        m_l = m_hold;
                        m_r = cv(wq[i].v);
                        m_lock = 1'b1;
                        m_hf = 1'b0;
                        e_sv++;
                    end
                end else begin
                    e_fe++;
                    m_hf = 1'b0;
                end
            end
            tr = 1'b1;
        end
        m_prev = wq[wq.size()-1].ch;
    endtask

    task automatic clr_cnt();
        n_sv1 = 0; n_sv2 = 0; n_fe1 = 0; n_fe2 = 0;
    endtask

    task automatic check_all(input string nm, input int esv, input int efe,
                             input logic [15:0] el, input logic [15:0] er,
                             input bit elock);
        chk({nm, " sv_lj"}, n_sv1, esv);
        chk({nm, " sv_is"}, n_sv2, esv);
        chk({nm, " fe_lj"}, n_fe1, efe);
        chk({nm, " fe_is"}, n_fe2, efe);
        chk({nm, " l_lj"}, al1, el);
        chk({nm, " r_lj"}, ar1, er);
        chk({nm, " l_is"}, al2, el);
        chk({nm, " r_is"}, ar2, er);
        chk({nm, " lk_lj"}, lk1, elock);
        chk({nm, " lk_is"}, lk2, elock);
        repeat (180) @(negedge clk);
        chk({nm, " lkmid_lj"}, lk1, elock);
        chk({nm, " lkmid_is"}, lk2, elock);
        repeat (120) @(negedge clk);
        chk({nm, " lkto_lj"}, lk1, 0);
        chk({nm, " lkto_is"}, lk2, 0);
        chk({nm, " hold_lj"}, {al1, ar1}, {el, er});
        chk({nm, " hold_is"}, {al2, ar2}, {el, er});
        m_lock = 1'b0;
        m_hf = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " al_lj"}, al1, 0);
        chk({nm, " ar_lj"}, ar1, 0);
        chk({nm, " sv_lj"}, sv1, 0);
        chk({nm, " fe_lj"}, fe1, 0);
        chk({nm, " lk_lj"}, lk1, 0);
        chk({nm, " al_is"}, al2, 0);
        chk({nm, " ar_is"}, ar2, 0);
        chk({nm, " sv_is"}, sv2, 0);
        chk({nm, " fe_is"}, fe2, 0);
        chk({nm, " lk_is"}, lk2, 0);
    endtask

    initial begin
        tot = 0; bad = 0;
        clr_cnt();
        reset_n = 1'b0;
        bck = 1'b0; ws = 1'b0; din_lj = 1'b0; din_is = 1'b0;
        last_d = 1'b0; last_rise_t = 0;
        m_l = '0; m_r = '0; m_hold = '0;
        m_hf = 1'b0; m_lock = 1'b0; m_prev = 1'b0;

        tab[0] = '{l:16'h1234, r:16'hABCD, rlen:16, el:16'h1234,
                   er:16'hABCD, esv:1, efe:0, elock:1'b1};
        tab[1] = '{l:16'h5A5A, r:16'h0F0F, rlen:10, el:16'h1234,
                   er:16'hABCD, esv:0, efe:1, elock:1'b0};
        tab[2] = '{l:16'hFFFF, r:16'h0001, rlen:16, el:16'hFFFF,
                   er:16'h0001, esv:1, efe:0, elock:1'b1};
        tab[3] = '{l:16'h8000, r:16'h8000, rlen:16, el:16'h8000,
                   er:16'h8000, esv:1, efe:0, elock:1'b1};
        tab[4] = '{l:16'h0000, r:16'h7FFF, rlen:20, el:16'h0000,
                   er:16'h7FFF, esv:1, efe:0, elock:1'b1};

        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            wq.delete();
            push(1'b1, 16, 16'h0000);
            push(1'b0, 16, tab[i].l);
            push(1'b1, tab[i].rlen, tab[i].r);
            push(1'b0, 16, 16'h0000);
            clr_cnt();
            run_words();
            model_run();
            check_all($sformatf("vec%0d", i), tab[i].esv, tab[i].efe,
                      cv(tab[i].el), cv(tab[i].er), tab[i].elock);
        end

        for (int b = 0; b < 8; b++) begin
            int n;
            bit ch;
            wq.delete();
            n = $urandom_range(4, 8);
            ch = 1'($urandom_range(0, 1));
            for (int k = 0; k < n; k++) begin
                int len;
                len = ($urandom_range(0, 4) == 0) ? $urandom_range(6, 22) : 16;
                push(ch, len, 16'($urandom));
                ch = ~ch;
            end
            clr_cnt();
            run_words();
            model_run();
            check_all($sformatf("rnd%0d", b), e_sv, e_fe, m_l, m_r, m_lock);
        end

        // reset in the middle of a left word
        wq.delete();
        push(1'b1, 16, 16'($urandom));
        push(1'b0, 16, 16'($urandom));
        push(1'b1, 16, 16'($urandom));
        push(1'b0, 7, 16'($urandom));
        run_words();
        reset_n = 1'b0;
        #1;
        chk_zero("midrst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m_l = '0; m_r = '0; m_hf = 1'b0; m_lock = 1'b0; m_prev = 1'b0;
        clr_cnt();
        wq.delete();
        push(1'b0, 9, 16'($urandom));
        push(1'b1, 16, 16'($urandom));
        push(1'b0, 16, 16'($urandom));
        push(1'b1, 16, 16'($urandom));
        push(1'b0, 16, 16'($urandom));
        run_words();
        model_run();
        chk("midrst pairs", e_sv, 1);
        check_all("postrst", e_sv, e_fe, m_l, m_r, m_lock);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
